sram_i100_arbiter: RTL and testbench
====================================

// Module: sram_i100_arbiter
// PURPOSE
//  Shares the single-port input-feature SRAM (3136 x 145b, 1-cycle registered read) between the
//  input loader (write requester) and the conv engine (read requester). Performs round-robin
//  arbitration, range checks addresses, returns read data with a valid strobe, and counts
//  completed loads. Sits directly between both requesters and the SRAM macro ports.
// PARAMETERS
//  WORD_AMOUNT   3136                    SRAM depth in words
//  BIT_PER_WORD  145                     SRAM word width
//  ADDR_W        $clog2(WORD_AMOUNT)=12  address width
// PORTS
//  clk             in   1        single clock, all logic on posedge
//  rst             in   1        synchronous, active-high reset
//  wr_valid        in   1        loader write request
//  wr_ready        out  1        write accepted this cycle
//  wr_addr         in   ADDR_W   write address
//  wr_data         in   145      write data
//  rd_valid        in   1        conv-engine read request
//  rd_ready        out  1        read accepted this cycle
//  rd_addr         in   ADDR_W   read address
//  rd_last         in   1        marks final read of a pass
//  rd_rvalid       out  1        read data valid (1 cycle after rd handshake)
//  rd_rdata        out  145      read data
//  rd_rlast        out  1        rd_last echoed with the response
//  addr_err        out  1        1-cycle pulse: a request with addr >= WORD_AMOUNT was accepted
//  load_clr        in   1        clears write counter and load_done
//  load_done       out  1        sticky: WORD_AMOUNT in-range writes accepted since clear
//  sram_we         out  1        to SRAM we
//  sram_addr       out  ADDR_W   to SRAM addr
//  sram_din        out  145      to SRAM din
//  sram_final_flag out  1        to SRAM final_flag
//  sram_dout       in   145      from SRAM dout
// BEHAVIOUR
//  - Reset: rd_rvalid=0, rd_rlast=0, addr_err=0, load_done=0, wr_cnt=0, rr_last=READ
//    (first contention goes to write). Combinational outputs with no request: wr_ready=rd_ready=0,
//    sram_we=0, sram_addr=0, sram_din=0, sram_final_flag=0.
//  - Arbitration (comb): only one valid -> grant it; both valid -> grant side != rr_last;
//    neither -> no grant. rr_last <= granted side on any grant; unchanged otherwise.
//  - wr_ready/rd_ready = grant, same cycle as valid (no bubble). At most one handshake/cycle.
//    Requester holds valid, addr, data, rd_last stable until ready.
//  - Write grant: sram_addr=wr_addr, sram_din=wr_data, sram_we=(wr_addr<WORD_AMOUNT).
//  - Read grant: sram_addr=rd_addr, sram_we=0, sram_final_flag=rd_last.
//  - Read response: cycle N handshake -> cycle N+1 rd_rvalid=1, rd_rlast=rd_last(N),
//    rd_rdata=sram_dout, or all-zero if rd_addr(N) out of range. No backpressure on response;
//    back-to-back reads give back-to-back rd_rvalid.
//  - Out-of-range (addr >= WORD_AMOUNT): handshake completes, no SRAM write, addr_err=1 in
//    cycle N+1 only; read still returns a (zero) response so the engine's count stays aligned.
//  - wr_cnt (12b) += 1 per in-range write handshake; when increment reaches WORD_AMOUNT,
//    load_done<=1 and wr_cnt saturates. Duplicate addresses count (writes, not unique words).
//  - load_clr: wr_cnt<=0, load_done<=0 next edge; load_clr with a write same cycle -> clear wins,
//    that write not counted (SRAM write still performed). Arbitration unaffected.
//  - rst mid-operation: in-flight read response dropped (rd_rvalid=0 next cycle), counters and
//    rr_last reset; SRAM contents untouched.
// TESTING
//  1. Write only: 3136 writes addr 0..3135, data=addr -> wr_ready every cycle, load_done=1 the
//     cycle after write 3135, not before.
//  2. Read after load: reads 0..3135 back-to-back, rd_last on 3135 -> rd_rvalid continuous,
//     rd_rdata=addr, rd_rlast only on final response, sram_final_flag on final request.
//  3. Contention: wr_valid=rd_valid=1 for 6 cycles after reset -> grants W,R,W,R,W,R; each
//     read data equals SRAM content at cycle of grant (incl. write-then-read same addr 10).
//  4. Range: write addr 3136, read addr 4095 -> both handshake, addr_err pulses 1 cycle each,
//     SRAM unchanged, read returns 0 with rd_rvalid=1.
//  5. load_clr same cycle as write #100 -> load_done stays 0 until 3136 further writes.
//  6. rst asserted cycle after a read handshake -> rd_rvalid=0, load_done=0, next contention
//     grants write first.

Source files
------------

// File: rtl/sram_i100_arbiter.sv
// Round-robin arbiter sharing the input-feature SRAM between the input loader (writes)
// and the conv engine (reads); range-checks addresses, returns read data and tracks load completion.
module sram_i100_arbiter #(
    parameter int WORD_AMOUNT  = 3136,
    parameter int BIT_PER_WORD = 145,
    parameter int ADDR_W       = $clog2(WORD_AMOUNT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [BIT_PER_WORD-1:0] wr_data,
    input  logic                    rd_valid,
    output logic                    rd_ready,
    input  logic [ADDR_W-1:0]       rd_addr,
    input  logic                    rd_last,
    output logic                    rd_rvalid,
    output logic [BIT_PER_WORD-1:0] rd_rdata,
    output logic                    rd_rlast,
    output logic                    addr_err,
    input  logic                    load_clr,
    output logic                    load_done,
    output logic                    sram_we,
    output logic [ADDR_W-1:0]       sram_addr,
    output logic [BIT_PER_WORD-1:0] sram_din,
    output logic                    sram_final_flag,
    input  logic [BIT_PER_WORD-1:0] sram_dout
);

    localparam logic [ADDR_W-1:0] WORD_LIM = ADDR_W'(WORD_AMOUNT);
    localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1);

    typedef enum logic {
        SIDE_WRITE = 1'b0,
        SIDE_READ  = 1'b1
    } side_e;

    side_e                    rr_last_r;
    side_e                    rr_last_nxt_s;
    logic                     grant_wr_s;
    logic                     grant_rd_s;
    logic                     rd_rvalid_r;
    logic                     rd_rlast_r;
    logic                     rd_oor_r;
    logic                     addr_err_r;
    logic [ADDR_W-1:0]        wr_cnt_r;
    logic [ADDR_W-1:0]        wr_cnt_inc_s;
    logic                     load_done_r;
    logic                     wr_in_range_s;
    logic                     rd_in_range_s;

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return (addr < WORD_LIM);
    endfunction

    assign wr_in_range_s = addr_in_range(wr_addr);
    assign rd_in_range_s = addr_in_range(rd_addr);
    assign wr_cnt_inc_s  = wr_cnt_r + CNT_ONE;

    // Round-robin state: side granted most recently; READ after reset so write wins first contention
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last_r <= SIDE_READ;
        end else begin
            rr_last_r <= rr_last_nxt_s;
        end
    end

    // Grant decision and next round-robin side
    always_comb begin
        grant_wr_s    = 1'b0;
        grant_rd_s    = 1'b0;
        rr_last_nxt_s = rr_last_r;
        case ({wr_valid, rd_valid})
            2'b10: grant_wr_s = 1'b1;
            2'b01: grant_rd_s = 1'b1;
            2'b11: begin
                if (rr_last_r == SIDE_READ) begin
                    grant_wr_s = 1'b1;
                end else begin
                    grant_rd_s = 1'b1;
                end
            end
            default: begin
                grant_wr_s = 1'b0;
                grant_rd_s = 1'b0;
            end
        endcase
        if (grant_wr_s) begin
            rr_last_nxt_s = SIDE_WRITE;
        end else if (grant_rd_s) begin
            rr_last_nxt_s = SIDE_READ;
        end else begin
            rr_last_nxt_s = rr_last_r;
        end
    end

    // Handshake and SRAM port muxing; out-of-range writes complete without touching the macro
    always_comb begin
        wr_ready        = 1'b0;
        rd_ready        = 1'b0;
        sram_we         = 1'b0;
        sram_addr       = {ADDR_W{1'b0}};
        sram_din        = {BIT_PER_WORD{1'b0}};
        sram_final_flag = 1'b0;
        if (grant_wr_s) begin
            wr_ready  = 1'b1;
            sram_we   = wr_in_range_s;
            sram_addr = wr_addr;
            sram_din  = wr_data;
        end else if (grant_rd_s) begin
            rd_ready        = 1'b1;
            sram_addr       = rd_addr;
            sram_final_flag = rd_last;
        end else begin
            sram_we = 1'b0;
        end
    end

    // Read response tracking, aligned with the SRAM's one-cycle registered read
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_rvalid_r <= 1'b0;
            rd_rlast_r  <= 1'b0;
            rd_oor_r    <= 1'b0;
            addr_err_r  <= 1'b0;
        end else begin
            rd_rvalid_r <= grant_rd_s;
            rd_rlast_r  <= grant_rd_s & rd_last;
            rd_oor_r    <= grant_rd_s & ~rd_in_range_s;
            addr_err_r  <= (grant_wr_s & ~wr_in_range_s) | (grant_rd_s & ~rd_in_range_s);
        end
    end

    // Load progress: saturating count of in-range writes; clear beats a same-cycle write
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_r    <= {ADDR_W{1'b0}};
            load_done_r <= 1'b0;
        end else if (load_clr) begin
            wr_cnt_r    <= {ADDR_W{1'b0}};
            load_done_r <= 1'b0;
        end else if (grant_wr_s && wr_in_range_s && (wr_cnt_r != WORD_LIM)) begin
            wr_cnt_r <= wr_cnt_inc_s;
            if (wr_cnt_inc_s == WORD_LIM) begin
                load_done_r <= 1'b1;
            end else begin
                load_done_r <= load_done_r;
            end
        end else begin
            wr_cnt_r    <= wr_cnt_r;
            load_done_r <= load_done_r;
        end
    end

    assign rd_rvalid = rd_rvalid_r;
    assign rd_rlast  = rd_rlast_r;
    assign addr_err  = addr_err_r;
    assign load_done = load_done_r;
    // Out-of-range reads return zeros so the engine sees a clean word
    assign rd_rdata  = (rd_rvalid_r && !rd_oor_r) ? sram_dout : {BIT_PER_WORD{1'b0}};

endmodule

// File: tb/tb_sram_i100_arbiter.sv
// Randomized and directed bench for sram_i100_arbiter against a behavioural model of
// arbitration, memory contents, response timing and load counting.
module tb_sram_i100_arbiter;

    localparam int WA = 3136;
    localparam int BW = 145;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid, wr_ready, rd_valid, rd_ready, rd_last;
    logic [AW-1:0] wr_addr, rd_addr, sram_addr;
    logic [BW-1:0] wr_data, rd_rdata, sram_din, sram_dout;
    logic          rd_rvalid, rd_rlast, addr_err, load_clr, load_done, sram_we, sram_final_flag;

    always #5 clk = ~clk;

    sram_i100_arbiter dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_last(rd_last),
        .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata), .rd_rlast(rd_rlast),
        .addr_err(addr_err), .load_clr(load_clr), .load_done(load_done),
        .sram_we(sram_we), .sram_addr(sram_addr), .sram_din(sram_din),
        .sram_final_flag(sram_final_flag), .sram_dout(sram_dout)
    );

    // SRAM macro stand-in; unmapped addresses read back all-ones to expose missing masking
    logic [BW-1:0] sram_mem [0:WA-1];
    always @(posedge clk) begin
        if (sram_we && (int'(sram_addr) < WA)) sram_mem[sram_addr] <= sram_din;
        sram_dout <= (int'(sram_addr) < WA) ? sram_mem[sram_addr] : {BW{1'b1}};
    end

    // Reference model state
    logic [BW-1:0] exp_mem [0:WA-1];
    bit            m_known, m_last_w, m_rv, m_rl, m_err, m_done;
    logic [BW-1:0] m_rd;
    int            m_cnt;
    int            n_chk = 0;
    int            n_fail = 0;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom, 17'($urandom)};
    endfunction

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 15) == 0) return AW'($urandom_range(WA, 4095));
        return AW'($urandom_range(0, WA - 1));
    endfunction

    // One clock cycle: drive, check against model, advance model at the edge
    task automatic step(input bit r, input bit wv, input logic [AW-1:0] wa, input logic [BW-1:0] wd,
                        input bit rv, input logic [AW-1:0] ra, input bit rl, input bit clr,
                        output bit gw, output bit gr);
        @(negedge clk);
        rst = r; wr_valid = wv; wr_addr = wa; wr_data = wd;
        rd_valid = rv; rd_addr = ra; rd_last = rl; load_clr = clr;
        #1;
        gw = wv && (!rv || !m_last_w);
        gr = rv && !gw;
        chk("wr_ready", BW'(wr_ready), BW'(gw));
        chk("rd_ready", BW'(rd_ready), BW'(gr));
        chk("sram_we", BW'(sram_we), BW'(gw && (int'(wa) < WA)));
        chk("sram_addr", BW'(sram_addr), gw ? BW'(wa) : (gr ? BW'(ra) : BW'(0)));
        chk("sram_din", sram_din, gw ? wd : BW'(0));
        chk("sram_final_flag", BW'(sram_final_flag), BW'(gr && rl));
        if (m_known) begin
            chk("rd_rvalid", BW'(rd_rvalid), BW'(m_rv));
            chk("rd_rlast", BW'(rd_rlast), BW'(m_rl));
            chk("addr_err", BW'(addr_err), BW'(m_err));
            chk("load_done", BW'(load_done), BW'(m_done));
            if (m_rv) chk("rd_rdata", rd_rdata, m_rd);
        end
        @(posedge clk);
        if (r) begin
            m_known = 1'b1; m_last_w = 1'b0; m_rv = 1'b0; m_rl = 1'b0;
            m_err = 1'b0; m_done = 1'b0; m_cnt = 0;
        end else begin
            m_rv  = gr;
            m_rl  = gr && rl;
            m_rd  = (gr && (int'(ra) < WA)) ? exp_mem[ra] : BW'(0);
            m_err = (gw && (int'(wa) >= WA)) || (gr && (int'(ra) >= WA));
            if (gw && (int'(wa) < WA)) exp_mem[wa] = wd;
            if (clr) begin
                m_cnt = 0; m_done = 1'b0;
            end else if (gw && (int'(wa) < WA) && (m_cnt < WA)) begin
                m_cnt++;
                if (m_cnt == WA) m_done = 1'b1;
            end
            if (gw) m_last_w = 1'b1;
            else if (gr) m_last_w = 1'b0;
        end
    endtask

    task automatic idle(input bit r);
        bit gw, gr;
        step(r, 1'b0, AW'(0), BW'(0), 1'b0, AW'(0), 1'b0, 1'b0, gw, gr);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        bit            gw, gr, pw, pr, prl, r;
        logic [AW-1:0] pwa, pra;
        logic [BW-1:0] pwd;
        int            wn, rn;
        for (int i = 0; i < WA; i++) exp_mem[i] = BW'(0);
        m_known = 1'b0; m_last_w = 1'b0; m_rv = 1'b0; m_rl = 1'b0;
        m_err = 1'b0; m_done = 1'b0; m_cnt = 0; m_rd = BW'(0);
        rst = 1'b1; wr_valid = 1'b0; rd_valid = 1'b0; wr_addr = '0; rd_addr = '0;
        wr_data = '0; rd_last = 1'b0; load_clr = 1'b0;

        idle(1'b1); idle(1'b1); idle(1'b0);

        // Full load, data = address
        for (int a = 0; a < WA; a++)
            step(1'b0, 1'b1, AW'(a), BW'(a), 1'b0, AW'(0), 1'b0, 1'b0, gw, gr);
        idle(1'b0);

        // Back-to-back read-out with rd_last on the final word
        for (int a = 0; a < WA; a++)
            step(1'b0, 1'b0, AW'(0), BW'(0), 1'b1, AW'(a), (a == WA - 1), 1'b0, gw, gr);
        idle(1'b0);

        // Contention straight after reset: write must win first, then alternate
        idle(1'b1);
        wn = 0; rn = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, AW'(10 + wn), rnd_data(), 1'b1, AW'(10 + rn), 1'b0, 1'b0, gw, gr);
            if (gw) wn++;
            if (gr) rn++;
        end
        idle(1'b0);

        // Out-of-range write and read
        step(1'b0, 1'b1, AW'(WA), {BW{1'b1}}, 1'b0, AW'(0), 1'b0, 1'b0, gw, gr);
        step(1'b0, 1'b0, AW'(0), BW'(0), 1'b1, AW'(4095), 1'b1, 1'b0, gw, gr);
        idle(1'b0); idle(1'b0);

        // Clear coinciding with write #100, then a full count of further writes
        idle(1'b1);
        for (int i = 0; i < 100; i++)
            step(1'b0, 1'b1, AW'(i), rnd_data(), 1'b0, AW'(0), 1'b0, (i == 99), gw, gr);
        for (int i = 0; i < WA; i++)
            step(1'b0, 1'b1, AW'((i * 7) % WA), rnd_data(), 1'b0, AW'(0), 1'b0, 1'b0, gw, gr);
        idle(1'b0);

        // Reset right after a read handshake, then contention
        step(1'b0, 1'b0, AW'(0), BW'(0), 1'b1, AW'(5), 1'b1, 1'b0, gw, gr);
        idle(1'b1);
        step(1'b0, 1'b1, AW'(20), rnd_data(), 1'b1, AW'(21), 1'b0, 1'b0, gw, gr);
        step(1'b0, 1'b0, AW'(0), BW'(0), 1'b1, AW'(21), 1'b0, 1'b0, gw, gr);
        idle(1'b0);

        // Randomized traffic; requests are held until accepted
        pw = 1'b0; pr = 1'b0; pwa = '0; pra = '0; pwd = '0; prl = 1'b0;
        gw = 1'b0; gr = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (gw || !pw) begin
                pw = ($urandom_range(0, 2) != 0); pwa = rnd_addr(); pwd = rnd_data();
            end
            if (gr || !pr) begin
                pr = ($urandom_range(0, 2) != 0); pra = rnd_addr(); prl = ($urandom_range(0, 7) == 0);
            end
            r = ($urandom_range(0, 399) == 0);
            step(r, pw && !r, pwa, pwd, pr && !r, pra, prl, ($urandom_range(0, 63) == 0), gw, gr);
        end
        idle(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
